// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus a full immediate into an instruction word and writes it
// to instruction memory at an auto-incrementing address. Optional macro: IMM_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_scr,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    function automatic logic [31:0] pack_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_rs1,
        input logic [4:0]  f_rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] iv
    );
        logic [31:0] w;
        case (fmt)
            3'b000:  w = {iv[11:0], f_rs1, f3, f_rd, op};
            3'b001:  w = {iv[11:5], f_rs2, f_rs1, f3, iv[4:0], op};
            3'b010:  w = {f7, f_rs2, f_rs1, f3, f_rd, op};
            3'b011:  w = {iv[12], iv[10:5], f_rs2, f_rs1, f3, iv[4:1], iv[11], op};
            3'b100:  w = {iv[20], iv[10:1], iv[11], iv[19:12], f_rd, op};
            3'b101:  w = {iv[31:12], f_rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic fmt_ok(input logic [2:0] fmt);
        return (fmt <= 3'b101);
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // Upper bits must be a pure sign extension of the field the format can encode.
    function automatic logic imm_ok(input logic [2:0] fmt, input logic [31:0] iv);
        logic ok;
        case (fmt)
            3'b000, 3'b001: ok = (&iv[31:11]) | ~(|iv[31:11]);
            3'b011:         ok = ~iv[0] & ((&iv[31:12]) | ~(|iv[31:12]));
            3'b100:         ok = ~iv[0] & ((&iv[31:20]) | ~(|iv[31:20]));
            3'b101:         ok = ~(|iv[11:0]);
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    state_t              state_r, next_state_s;
    logic                accept_s, bundle_ok_s, in_ready_s;
    logic                mem_we_r, err_r, full_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [CNT_W-1:0]    count_r;

    // Bundle validity check applied at the acceptance edge.
    always_comb begin
`ifdef IMM_RANGE_CHECK_EN
        bundle_ok_s = fmt_ok(imm_scr) & imm_ok(imm_scr, imm);
`else
        bundle_ok_s = fmt_ok(imm_scr);
`endif
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        in_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = ~full_r & ~base_load;
                if (in_valid && in_ready_s) begin
                    accept_s = 1'b1;
                    if (bundle_ok_s) begin
                        next_state_s = WRITE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WRITE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, write pointer, count and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            mem_we_r <= 1'b0;
            err_r    <= 1'b0;
            full_r   <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 32'h0000_0000;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            err_r   <= accept_s & ~bundle_ok_s;
            if (accept_s && bundle_ok_s) begin
                wdata_r  <= pack_word(imm_scr, opcode, rd, rs1, rs2, funct3, funct7, imm);
                mem_we_r <= 1'b1;
            end else if (state_r == WRITE && mem_ack) begin
                mem_we_r <= 1'b0;
                addr_r   <= addr_r + ADDR_W'(4);
                count_r  <= count_r + CNT_W'(1);
                full_r   <= ((count_r + CNT_W'(1)) == CNT_W'(DEPTH));
            end else if (state_r == IDLE && base_load) begin
                addr_r  <= base_addr & ~(ADDR_W'(3));
                count_r <= {CNT_W{1'b0}};
                full_r  <= 1'b0;
            end else begin
                mem_we_r <= mem_we_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign err       = err_r;
    assign full      = full_r;
    assign count     = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=2): expected writes are queued at drive time
// and compared when the memory handshake completes.
module tb_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        imm_scr;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              err;
    logic              full;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .imm_scr(imm_scr), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err(err), .full(full), .count(count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    int          errs = 0;
    int          we_run = 0;
    int          last_we_len = 0;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] exp_ptr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Write monitor: hold stability while waiting, scoreboard compare on handshake.
    always @(negedge clk) begin
        wr_t e;
        if (err) errs++;
        if (mem_we) begin
            if (we_run == 0) begin
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end else begin
                check("hold_addr", mem_addr, hold_addr);
                check("hold_data", mem_wdata, hold_data);
                check("hold_ready", {31'b0, in_ready}, 32'h0);
            end
            we_run++;
            if (mem_ack) begin
                writes++;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '{addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                last_we_len = we_run;
                we_run = 0;
            end
        end else begin
            we_run = 0;
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] f_rd,
                        input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] iv,
                        input bit exp_write, input logic [31:0] exp_data);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", {31'b0, in_ready}, 32'h1);
        if (exp_write) begin
            exp_q.push_back('{addr: exp_ptr, data: exp_data});
            exp_ptr = exp_ptr + 32'd4;
        end
        imm_scr = fmt; opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        funct3 = f3; funct7 = f7; imm = iv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (writes < target && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("writes", writes, target);
    endtask

    task automatic do_base(input logic [31:0] a);
        base_addr = a;
        base_load = 1'b1;
        #1;
        check("ready_on_load", {31'b0, in_ready}, 32'h0);
        @(posedge clk); #1;
        base_load = 1'b0;
        exp_ptr = a & 32'hFFFF_FFFC;
        check("base_addr", mem_addr, exp_ptr);
        check("base_count", 32'(count), 32'h0);
        check("base_full", {31'b0, full}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, e0;
        rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0; imm_scr = 3'b000;
        opcode = 7'h0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
        imm = 32'h0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_full", {31'b0, full}, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;

        // I and S with ack tied high; low address bits of base are dropped.
        do_base(32'h0000_1003);
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        wait_writes(1);
        check("we_len", last_we_len, 1);
        check("count1", 32'(count), 32'h1);
        send(3'b001, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE21_AE23);
        wait_writes(2);
        check("full_set", {31'b0, full}, 32'h1);
        check("full_count", 32'(count), 32'h2);
        check("full_ready", {31'b0, in_ready}, 32'h0);

        // Bundle presented while full: not accepted, no err.
        w0 = writes; e0 = errs;
        imm_scr = 3'b000; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("full_nowrite", writes, w0);
        check("full_noerr", errs, e0);
        check("full_stay", {31'b0, mem_we}, 32'h0);

        // J with a 3-cycle ack delay, then U.
        do_base(32'h0000_0100);
        mem_ack = 1'b0;
        send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0080_00EF);
        repeat (3) @(posedge clk);
        #1;
        check("delay_we", {31'b0, mem_we}, 32'h1);
        check("delay_ready", {31'b0, in_ready}, 32'h0);
        mem_ack = 1'b1;
        wait_writes(3);
        send(3'b101, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        wait_writes(4);

        // Invalid format, then an out-of-range I immediate.
        do_base(32'h0000_0200);
        e0 = errs;
        send(3'b111, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("inv_err", errs, e0 + 1);
        check("inv_nowrite", writes, 4);
        check("inv_count", 32'(count), 32'h0);
`ifdef IMM_RANGE_CHECK_EN
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("range_err", errs, e0 + 2);
        check("range_nowrite", writes, 4);
        check("range_count", 32'(count), 32'h0);
`else
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h8000_0093);
        wait_writes(5);
        check("trunc_err", errs, e0 + 1);
        check("trunc_count", 32'(count), 32'h1);
`endif

        // R and negative B.
        do_base(32'h0000_0300);
        w0 = writes;
        send(3'b010, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'h0020_81B3);
        wait_writes(w0 + 1);
        send(3'b011, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
        wait_writes(w0 + 2);
        check("rb_count", 32'(count), 32'h2);

        // Reset while a write is pending.
        do_base(32'h0000_0400);
        mem_ack = 1'b0;
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        check("pend_we", {31'b0, mem_we}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_we", {31'b0, mem_we}, 32'h0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_count", 32'(count), 32'h0);
        exp_q.delete();
        exp_ptr = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        w0 = writes;
        send(3'b000, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'h0070_0113);
        wait_writes(w0 + 1);
        check("post_rst_count", 32'(count), 32'h1);
        check("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate extender. Takes decoded instruction fields plus a full 32-bit immediate and packs them into a RISC-V RV32I instruction word.
- Writes each packed word into instruction memory at an auto-incrementing word address.
- Used by the debug/program-loader path to assemble test programs in place, without an external toolchain.

Parameters:
- ADDR_W, 32, width of the instruction memory byte address.
- DEPTH, 1024, maximum number of words written after a base load before the block reports full.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- base_load  input  1  one-cycle pulse; loads base_addr into the write pointer and clears count.
- base_addr  input  ADDR_W  start byte address; bits [1:0] are ignored and forced to 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle.
- imm_scr  input  3  format: 000 I, 001 S, 010 R, 011 B, 100 J, 101 U; 110 and 111 are invalid.
- opcode  input  7  instruction bits [6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  function code 3.
- funct7  input  7  function code 7 (R format only).
- imm  input  32  full, unscaled immediate value.
- mem_we  output  1  write request to instruction memory.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  32  packed instruction word.
- mem_ack  input  1  memory accepted the write; sampled while mem_we=1.
- err  output  1  one-cycle pulse when a bundle is rejected.
- full  output  1  DEPTH words have been written since the last base load.
- count  output  $clog2(DEPTH+1)  number of words written since the last base load.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, err=0, full=0, count=0, state=IDLE. in_ready is then 1.
- State IDLE:
  - in_ready = ~full & ~base_load.
  - When in_valid & in_ready, the bundle is captured and encoded into mem_wdata at that edge.
  - A valid bundle moves to WRITE. A rejected bundle pulses err next cycle and stays in IDLE.
- State WRITE:
  - mem_we=1, and mem_addr and mem_wdata are held stable; in_ready=0.
  - On mem_ack: mem_we drops next cycle, mem_addr += 4, count += 1, full sets when count reaches DEPTH, and the state returns to IDLE.
- Throughput and latency:
  - Minimum 2 cycles per word: accept edge, then a WRITE cycle with mem_ack=1.
  - mem_we rises 1 cycle after acceptance.
- Encoding (imm bits as given; no shifting by the caller):
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - R: {funct7,rs2,rs1,funct3,rd,opcode}; imm is ignored.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - U: {imm[31:12],rd,opcode}
- Invalid imm_scr (110 or 111): the bundle is rejected. err pulses, nothing is written, and pointer and count are unchanged.
- base_load:
  - Honoured in IDLE only; ignored in WRITE, and the current write completes first.
  - Takes effect at the edge: mem_addr = {base_addr[ADDR_W-1:2],2'b00}, count=0, full=0.
- full:
  - While full=1, in_ready=0 and bundles are not accepted (no err).
  - The write pointer does not wrap; only base_load or rst clears full.
- rst asserted mid-WRITE: the write is abandoned and mem_we drops immediately (asynchronously). All state returns to its reset value.
- mem_ack outside WRITE is ignored.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: the immediate is validated at acceptance, and an out-of-range bundle is rejected like an invalid format (err pulse, no write).
  - I/S: imm[31:11] must be all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - R: never checked.
- Undefined: no range check; unused imm bits are silently dropped, and err fires only for an invalid format.

Test Plan:
- I encode: imm_scr=000, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5, with mem_ack tied to 1. Expect mem_wdata=0x00500093 at mem_addr=base; mem_we high for exactly 1 cycle; count=1.
- S encode with negative imm: imm_scr=001, opcode=0x23, rs1=3, rs2=2, funct3=2, imm=0xFFFFFFFC. Expect 0xFE21AE23 at base+4.
- J then U encode: jal rd=1, imm=8 gives 0x008000EF. lui rd=5, imm=0x12345000 gives 0x123452B7. mem_ack is delayed 3 cycles on the first write; mem_we, mem_addr and mem_wdata must be held stable and in_ready=0 throughout.
- Invalid format: imm_scr=111, then I imm=2048 (addi x1,x0).
  - Both builds: the 111 bundle gives an err pulse with no write.
  - With the macro: the imm=2048 bundle gives an err pulse with no write.
  - Without the macro: imm=2048 is written as 0x80000093.
- Full and base load: DEPTH=2, write 2 words, then expect full=1 and in_ready=0. Present a third bundle and expect it not accepted and no err. base_load=0x100 then gives full=0, count=0, and the next word lands at 0x100.
- Reset mid-WRITE: assert rst while mem_we=1 with mem_ack=0. Expect mem_we=0 immediately, count=0 and mem_addr=0. The next bundle writes at address 0.
